gray_rx_decoder: RTL and testbench

Receive-side companion to the gray counter. Samples a Gray-coded count bus driven by a gray counter, converts it to binary and checks every step for legal single-increment progression. Tracks lock status and keeps a saturating error counter. Sits at the consumer end of a Gray-coded count interface, e.g. a pointer or timestamp crossing a module boundary.

---
 rtl/gray_rx_decoder.sv | 136 +++++++++++++
 tb/tb_gray_rx_decoder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_rx_decoder.sv
// Gray-code receiver: converts each valid sample to binary, checks single-increment progression, tracks lock and counts bad steps.
// One-cycle registered latency from a valid sample to bin_out/bin_valid/step_err; no backpressure, a sample is taken on every valid cycle.
module gray_rx_decoder #(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             gray_valid,
  input  logic             clear_err,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             step_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam int GW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [GW-1:0]      good_q, good_d;
  logic               bin_vld_q, bin_vld_d;
  logic               step_err_q, step_err_d;
  logic               locked_q, locked_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0]   gray_bin;
  logic [WIDTH-1:0]   prev_inc;
  logic [GW-1:0]      good_inc;
  logic               is_inc;
  logic               is_hold;

  // Binary bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    gray_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      gray_bin[i] = ^(gray_in >> i);
    end
  end

  assign prev_inc = prev_q + WIDTH'(1);
  assign good_inc = good_q + GW'(1);
  assign is_inc   = (gray_bin == prev_inc);
  assign is_hold  = (gray_bin == prev_q);

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    good_d     = good_q;
    bin_d      = bin_q;
    bin_vld_d  = 1'b0;
    step_err_d = 1'b0;

    if (gray_valid) begin
      bin_vld_d = 1'b1;
      bin_d     = gray_bin;
      prev_d    = gray_bin;
      case (state_q)
        IDLE: begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
        ACQUIRE: begin
          if (is_inc) begin
            if (good_inc == GW'(LOCK_CNT)) begin
              state_d = LOCKED;
              good_d  = '0;
            end else begin
              good_d = good_inc;
            end
          end else if (!is_hold) begin
            step_err_d = 1'b1;
            good_d     = '0;
          end
        end
        LOCKED: begin
          if (!is_inc && !is_hold) begin
            step_err_d = 1'b1;
            state_d    = ACQUIRE;
            good_d     = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    locked_d = (state_d == LOCKED);

    // A clear coinciding with an error leaves that error counted.
    err_cnt_d = err_cnt_q;
    if (clear_err) begin
      err_cnt_d = step_err_d ? ERR_W'(1) : '0;
    end else if (step_err_d && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      good_q     <= '0;
      bin_q      <= '0;
      bin_vld_q  <= 1'b0;
      step_err_q <= 1'b0;
      locked_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      good_q     <= good_d;
      bin_q      <= bin_d;
      bin_vld_q  <= bin_vld_d;
      step_err_q <= step_err_d;
      locked_q   <= locked_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bin_out   = bin_q;
  assign bin_valid = bin_vld_q;
  assign step_err  = step_err_q;
  assign locked    = locked_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Randomized and directed bench for gray_rx_decoder against a behavioural step model.
module tb_gray_rx_decoder;
  localparam int WIDTH    = 8;
  localparam int LOCK_CNT = 4;
  localparam int ERR_W    = 8;
  localparam int VW       = WIDTH + ERR_W + 3;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] gray_in;
  logic             gray_valid;
  logic             clear_err;
  logic [WIDTH-1:0] bin_out;
  logic             bin_valid;
  logic             step_err;
  logic             locked;
  logic [ERR_W-1:0] err_count;

  int total = 0;
  int bad   = 0;

  gray_rx_decoder #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .gray_valid(gray_valid),
    .clear_err(clear_err), .bin_out(bin_out), .bin_valid(bin_valid),
    .step_err(step_err), .locked(locked), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [VW-1:0] dut_vec;
  assign dut_vec = {bin_out, bin_valid, step_err, locked, err_count};

  // Reference model: plain integer bookkeeping of the decoder's observable behaviour.
  int m_bin, m_prev, m_good, m_errc;
  bit m_vld, m_err, m_lock, m_seen;

  function automatic int gray2bin(input int g);
    int b = g;
    for (int s = 1; s < WIDTH; s = s * 2) b = b ^ (b >> s);
    return b & ((1 << WIDTH) - 1);
  endfunction

  function automatic logic [WIDTH-1:0] bin2gray(input int b);
    int m = b & ((1 << WIDTH) - 1);
    return WIDTH'(m ^ (m >> 1));
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {WIDTH'(m_bin), m_vld, m_err, m_lock, ERR_W'(m_errc)};
  endfunction

  task automatic model_step(input bit r, input int g, input bit v, input bit c);
    int b, d;
    if (!r) begin
      m_bin = 0; m_prev = 0; m_good = 0; m_errc = 0;
      m_vld = 0; m_err = 0; m_lock = 0; m_seen = 0;
      return;
    end
    m_vld = v;
    m_err = 0;
    if (v) begin
      b = gray2bin(g);
      if (!m_seen) begin
        m_seen = 1;
        m_good = 0;
      end else begin
        d = (b - m_prev) & ((1 << WIDTH) - 1);
        if (d == 1) begin
          if (!m_lock) begin
            m_good++;
            if (m_good == LOCK_CNT) begin
              m_lock = 1;
              m_good = 0;
            end
          end
        end else if (d != 0) begin
          m_err  = 1;
          m_lock = 0;
          m_good = 0;
        end
      end
      m_prev = b;
      m_bin  = b;
    end
    if (m_err) m_errc = c ? 1 : ((m_errc < (1 << ERR_W) - 1) ? m_errc + 1 : m_errc);
    else if (c) m_errc = 0;
  endtask

  // Drives one clock of stimulus and advances the model; outputs are stable #1 after the edge.
  task automatic cyc(input bit r, input logic [WIDTH-1:0] g, input bit v, input bit c);
    @(negedge clk);
    rst_n = r; gray_in = g; gray_valid = v; clear_err = c;
    @(posedge clk);
    model_step(r, int'(g), v, c);
    #1;
  endtask

  task automatic test_reset();
    cyc(0, 8'hA5, 1, 1);
    cyc(0, 8'h3C, 1, 0);
    total++;
    if (dut_vec !== {VW{1'b0}}) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", dut_vec);
    end
  endtask

  task automatic test_count_up();
    logic [WIDTH-1:0] seq [10] = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04, 8'h0C, 8'h0D};
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, seq[i], 1, 0);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL count_up_vec[%0d]: got %h want %h", i, dut_vec, exp_vec());
      end
      total++;
      if (bin_out !== WIDTH'(i) || locked !== (i >= 4)) begin
        bad++; $display("FAIL count_up_bin_lock[%0d]: got %0d/%b want %0d/%b", i, bin_out, locked, i, i >= 4);
      end
    end
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] seq [5] = '{8'h83, 8'h81, 8'h80, 8'h00, 8'h01};
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, seq[i], 1, 0);
      total++;
      if (dut_vec !== exp_vec() || step_err !== 1'b0) begin
        bad++; $display("FAIL wrap_vec[%0d]: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    total++;
    if (locked !== 1'b1 || bin_out !== 8'd1) begin
      bad++; $display("FAIL wrap_lock: got locked=%b bin=%0d want 1/1", locked, bin_out);
    end
  endtask

  task automatic test_skip();
    cyc(0, 0, 0, 0);
    for (int i = 0; i <= 5; i++) cyc(1, bin2gray(i), 1, 0);
    cyc(1, 8'h04, 1, 0);
    total++;
    if (step_err !== 1'b1 || locked !== 1'b0 || err_count !== 8'd1 || bin_out !== 8'd7) begin
      bad++; $display("FAIL skip_err: got err=%b lock=%b cnt=%0d bin=%0d want 1/0/1/7",
                      step_err, locked, err_count, bin_out);
    end
    for (int i = 8; i <= 11; i++) begin
      cyc(1, bin2gray(i), 1, 0);
      total++;
      if (dut_vec !== exp_vec() || locked !== (i == 11)) begin
        bad++; $display("FAIL skip_relock[%0d]: got %h want %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_hold_gap();
    cyc(0, 0, 0, 0);
    for (int i = 0; i <= 2; i++) cyc(1, bin2gray(i), 1, 0);
    cyc(1, 8'h02, 1, 0);
    cyc(1, 8'h02, 0, 0);
    total++;
    if (bin_valid !== 1'b0 || bin_out !== 8'd3 || step_err !== 1'b0) begin
      bad++; $display("FAIL gap_hold: got vld=%b bin=%0d err=%b want 0/3/0", bin_valid, bin_out, step_err);
    end
    cyc(1, 8'h02, 1, 0);
    total++;
    if (dut_vec !== exp_vec() || step_err !== 1'b0 || locked !== 1'b0) begin
      bad++; $display("FAIL gap_resume: got %h want %h", dut_vec, exp_vec());
    end
    cyc(1, bin2gray(4), 1, 0);
    total++;
    if (locked !== 1'b1) begin
      bad++; $display("FAIL gap_good_kept: got locked=%b want 1", locked);
    end
  endtask

  task automatic test_saturate_clear();
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 300; i++) cyc(1, (i % 2 == 0) ? 8'h00 : 8'h05, 1, 0);
    total++;
    if (err_count !== 8'd255 || dut_vec !== exp_vec()) begin
      bad++; $display("FAIL sat_count: got %0d want 255", err_count);
    end
    cyc(1, 8'h00, 1, 1);
    total++;
    if (err_count !== 8'd1 || step_err !== 1'b1) begin
      bad++; $display("FAIL clear_with_err: got cnt=%0d err=%b want 1/1", err_count, step_err);
    end
    cyc(1, 8'h00, 0, 1);
    total++;
    if (err_count !== 8'd0) begin
      bad++; $display("FAIL clear_alone: got %0d want 0", err_count);
    end
  endtask

  task automatic test_reset_midstream();
    cyc(0, 0, 0, 0);
    for (int i = 0; i <= 5; i++) cyc(1, bin2gray(i), 1, 0);
    total++;
    if (locked !== 1'b1) begin
      bad++; $display("FAIL mid_prelock: got %b want 1", locked);
    end
    cyc(0, bin2gray(6), 1, 0);
    total++;
    if (dut_vec !== {VW{1'b0}}) begin
      bad++; $display("FAIL mid_reset: got %h want 0", dut_vec);
    end
    cyc(1, 8'h55, 1, 0);
    total++;
    if (bin_out !== 8'h66 || step_err !== 1'b0 || bin_valid !== 1'b1 || locked !== 1'b0) begin
      bad++; $display("FAIL mid_first: got bin=%h err=%b vld=%b lock=%b want 66/0/1/0",
                      bin_out, step_err, bin_valid, locked);
    end
  endtask

  task automatic test_random();
    int cur = 0;
    int sel;
    bit r, v, c;
    for (int n = 0; n < 2000; n++) begin
      r   = ($urandom_range(0, 199) != 0);
      v   = ($urandom_range(0, 3) != 0);
      c   = ($urandom_range(0, 19) == 0);
      sel = $urandom_range(0, 9);
      if (sel <= 6) cur = cur + 1;
      else if (sel == 9) cur = $urandom_range(0, (1 << WIDTH) - 1);
      cyc(r, bin2gray(cur), v, c);
      total++;
      if (dut_vec !== exp_vec()) begin
        bad++; $display("FAIL random[%0d]: got %h want %h", n, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; gray_in = '0; gray_valid = 1'b0; clear_err = 1'b0;
    test_reset();
    test_count_up();
    test_wrap();
    test_skip();
    test_hold_gap();
    test_saturate_clear();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
